match_ctrl: RTL
===============

MATCH_CTRL -- requirements
Module: match_ctrl

Interface
REQ-001 SHALL have parameter WIN_SCORE, default 7, points needed to win the match (range 1..15).
REQ-002 SHALL have parameter HOLD_CYCLES, default 50000000, number of cycles the field is held cleared after a point (minimum 1).
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 500000000, PLAY inactivity limit; used only when MATCH_CTRL_TIMEOUT_EN is defined.
REQ-004 SHALL have port clk, input, 1, the single system clock; all state updates on its rising edge.
REQ-005 SHALL have port reset, input, 1, synchronous active-low reset; 0 sampled at a clk edge resets the block.
REQ-006 SHALL have port start, input, 1, one-cycle pulse that starts a match.
REQ-007 SHALL have port L, input, 1, conditioned one-cycle left-player press pulse.
REQ-008 SHALL have port R, input, 1, conditioned one-cycle right-player press pulse.
REQ-009 SHALL have port left_edge, input, 1, leftmost playfield light lit (left player scored).
REQ-010 SHALL have port right_edge, input, 1, rightmost playfield light lit (right player scored).
REQ-011 SHALL have port play_L, output, 1, gated left press forwarded to the light chain.
REQ-012 SHALL have port play_R, output, 1, gated right press forwarded to the light chain.
REQ-013 SHALL have port field_clr, output, 1, level that holds the light chain at centre-only.
REQ-014 SHALL have port left_score, output, 4, left player points.
REQ-015 SHALL have port right_score, output, 4, right player points.
REQ-016 SHALL have port winner, output, 2, 00 none, 01 left, 10 right.
REQ-017 SHALL have port state, output, 2, 00 IDLE, 01 PLAY, 10 POINT, 11 OVER.

Function
REQ-018 SHALL implement four states IDLE, PLAY, POINT, OVER; state, scores, winner and field_clr registered.
REQ-019 play_L SHALL be combinational: L & ~R & (state==PLAY); play_R likewise with L/R swapped; simultaneous L and R forward nothing.
REQ-020 IDLE: field_clr=1, scores held; start -> PLAY next cycle with field_clr=0.
REQ-021 PLAY: left_edge=1 and right_edge=0 -> left_score+1, enter POINT next cycle.
REQ-022 PLAY: right_edge=1 and left_edge=0 -> right_score+1, enter POINT next cycle.
REQ-023 PLAY: both edges in one cycle -> no score change, enter POINT.
REQ-024 POINT: field_clr=1 for exactly HOLD_CYCLES cycles, counter starting at entry; presses not forwarded.
REQ-025 POINT exit: either score == WIN_SCORE -> OVER with winner set; otherwise -> PLAY with field_clr=0.
REQ-026 Scores SHALL saturate at WIN_SCORE and never wrap.
REQ-027 OVER: field_clr=1, scores and winner held, L/R ignored; start -> scores 0, winner 00, PLAY next cycle.
REQ-028 start SHALL be ignored in PLAY and POINT.
REQ-029 left_edge/right_edge SHALL be ignored outside PLAY.

Reset
REQ-030 reset=0 at a clk edge SHALL force state IDLE, left_score 0, right_score 0, winner 00, field_clr 1, hold/timeout counters 0, regardless of current state.
REQ-031 Reset asserted mid-POINT or mid-OVER SHALL abandon the hold and discard the match with no point awarded.
REQ-032 While reset=0, play_L and play_R SHALL be 0.

Configuration
REQ-033 MATCH_CTRL_TIMEOUT_EN defined: PLAY counts cycles since the last L or R pulse; at TIMEOUT_CYCLES consecutive idle cycles SHALL enter POINT with no score change.
REQ-034 MATCH_CTRL_TIMEOUT_EN undefined: no timeout counter is built; PLAY exits only on edge inputs.

Verification (bench: WIN_SCORE=3, HOLD_CYCLES=4, TIMEOUT_CYCLES=8)
REQ-035 reset=0 one cycle, then start pulse -> state 00 then 01, field_clr 1 then 0, scores 0.
REQ-036 In PLAY, L and R high same cycle -> play_L=0, play_R=0; L alone -> play_L=1 same cycle.
REQ-037 In PLAY, left_edge one cycle -> left_score 1, state 10 for 4 cycles with field_clr=1, then state 01.
REQ-038 Three right_edge points -> right_score 3, after hold state 11, winner 10; further right_edge leaves score 3; start -> scores 0, state 01.
REQ-039 reset=0 during POINT hold cycle 2 -> next cycle state 00, scores 0, field_clr 1.
REQ-040 With MATCH_CTRL_TIMEOUT_EN, 8 idle PLAY cycles -> state 10, scores unchanged; without it, state stays 01.

Source files
------------

// File: rtl/match_ctrl.sv
// Two-player match controller: gates presses, scores points, holds the field after each point.
// Optional PLAY inactivity timeout is built only when MATCH_CTRL_TIMEOUT_EN is defined.
module match_ctrl #(
    parameter int unsigned WIN_SCORE      = 7,
    parameter int unsigned HOLD_CYCLES    = 50000000,
    parameter int unsigned TIMEOUT_CYCLES = 500000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       L,
    input  logic       R,
    input  logic       left_edge,
    input  logic       right_edge,
    output logic       play_L,
    output logic       play_R,
    output logic       field_clr,
    output logic [3:0] left_score,
    output logic [3:0] right_score,
    output logic [1:0] winner,
    output logic [1:0] state
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        PLAY  = 2'b01,
        POINT = 2'b10,
        OVER  = 2'b11
    } state_t;

    localparam int unsigned HOLD_W    = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [3:0] WIN = 4'(WIN_SCORE);

    state_t            state_q, state_d;
    logic [3:0]        left_score_q, left_score_d;
    logic [3:0]        right_score_q, right_score_d;
    logic [1:0]        winner_q, winner_d;
    logic              field_clr_q, field_clr_d;
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;

`ifdef MATCH_CTRL_TIMEOUT_EN
    localparam int unsigned TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
`endif

    always_comb begin
        state_d       = state_q;
        left_score_d  = left_score_q;
        right_score_d = right_score_q;
        winner_d      = winner_q;
        hold_cnt_d    = '0;
`ifdef MATCH_CTRL_TIMEOUT_EN
        to_cnt_d      = '0;
`endif
        case (state_q)
            IDLE: begin
                if (start) state_d = PLAY;
            end
            PLAY: begin
                if (left_edge && !right_edge) begin
                    if (left_score_q != WIN) left_score_d = left_score_q + 4'd1;
                    state_d = POINT;
                end else if (right_edge && !left_edge) begin
                    if (right_score_q != WIN) right_score_d = right_score_q + 4'd1;
                    state_d = POINT;
                end else if (left_edge && right_edge) begin
                    state_d = POINT;
`ifdef MATCH_CTRL_TIMEOUT_EN
                // Any press restarts the idle count; reaching the limit ends the rally unscored.
                end else if (L || R) begin
                    to_cnt_d = '0;
                end else if (to_cnt_q == TO_LAST) begin
                    state_d = POINT;
                end else begin
                    to_cnt_d = to_cnt_q + 1'b1;
`endif
                end
            end
            POINT: begin
                if (hold_cnt_q == HOLD_LAST) begin
                    if (left_score_q == WIN) begin
                        winner_d = 2'b01;
                        state_d  = OVER;
                    end else if (right_score_q == WIN) begin
                        winner_d = 2'b10;
                        state_d  = OVER;
                    end else begin
                        state_d = PLAY;
                    end
                end else begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                end
            end
            OVER: begin
                if (start) begin
                    left_score_d  = '0;
                    right_score_d = '0;
                    winner_d      = '0;
                    state_d       = PLAY;
                end
            end
            default: state_d = IDLE;
        endcase
        field_clr_d = (state_d != PLAY);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q       <= IDLE;
            left_score_q  <= '0;
            right_score_q <= '0;
            winner_q      <= '0;
            field_clr_q   <= 1'b1;
            hold_cnt_q    <= '0;
`ifdef MATCH_CTRL_TIMEOUT_EN
            to_cnt_q      <= '0;
`endif
        end else begin
            state_q       <= state_d;
            left_score_q  <= left_score_d;
            right_score_q <= right_score_d;
            winner_q      <= winner_d;
            field_clr_q   <= field_clr_d;
            hold_cnt_q    <= hold_cnt_d;
`ifdef MATCH_CTRL_TIMEOUT_EN
            to_cnt_q      <= to_cnt_d;
`endif
        end
    end

    // Gated by reset too, so a press cannot leak out while reset is pending in PLAY.
    assign play_L      = L & ~R & (state_q == PLAY) & reset;
    assign play_R      = R & ~L & (state_q == PLAY) & reset;
    assign field_clr   = field_clr_q;
    assign left_score  = left_score_q;
    assign right_score = right_score_q;
    assign winner      = winner_q;
    assign state       = state_q;

endmodule
